// File: rtl/jtkunio_pkg.sv
// Shared constants for the kunio graphics ROM arbiter: FSM states,
// requester indices and the round-robin helpers.
package jtkunio_pkg;

   localparam int SDRAM_AW = 22;
   localparam int DW       = 32;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_ACK  = 2'd1;
   localparam logic [1:0] WAIT_DATA = 2'd2;

   localparam logic [1:0] CHAR = 2'd0;
   localparam logic [1:0] SCR  = 2'd1;
   localparam logic [1:0] OBJ  = 2'd2;

   function automatic logic [1:0] next_req(input logic [1:0] r);
      case (r)
         CHAR:    return SCR;
         SCR:     return OBJ;
         default: return CHAR;
      endcase
   endfunction

   // First missing requester found when walking CHAR,SCR,OBJ from start.
   function automatic logic [1:0] rr_pick(input logic [2:0] miss, input logic [1:0] start);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       got;
      idx  = start;
      pick = start;
      got  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!got && miss[idx]) begin
            pick = idx;
            got  = 1'b1;
         end
         idx = next_req(idx);
      end
      return pick;
   endfunction

endpackage

// File: rtl/jtkunio_arb_slot.sv
// One-word ROM cache slot: tag, valid and data registers plus the
// combinational hit compare against the requester's current address.
module jtkunio_arb_slot
   import jtkunio_pkg::*;
#(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          wr,
   input  logic [AW-1:0] wr_tag,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] data,
   output logic          ok
);

   logic [AW-1:0] tag;
   logic          valid;
   logic [DW-1:0] data_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag    <= '0;
         valid  <= 1'b0;
         data_r <= '0;
      end else if (wr) begin
         tag    <= wr_tag;
         valid  <= 1'b1;
         data_r <= wr_data;
      end
   end

   assign ok   = cs & valid & (addr == tag);
   assign data = data_r;

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Round-robin arbiter sharing one SDRAM read port between the char,
// scroll and object ROM fetchers, each backed by a one-word slot.
module jtkunio_gfx_arb
   import jtkunio_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
   parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h08000,
   parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h28000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                char_cs,
   input  logic [13:0]         char_addr,
   output logic [DW-1:0]       char_data,
   output logic                char_ok,
   input  logic                scr_cs,
   input  logic [16:0]         scr_addr,
   output logic [DW-1:0]       scr_data,
   output logic                scr_ok,
   input  logic                obj_cs,
   input  logic [17:0]         obj_addr,
   output logic [DW-1:0]       obj_data,
   output logic                obj_ok,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                sdram_rdy,
   input  logic [DW-1:0]       sdram_din
);

   logic [1:0]          state;
   logic [1:0]          grant;
   logic [1:0]          rr;
   logic [17:0]         ctag;
   logic [2:0]          miss;
   logic [1:0]          pick;
   logic [SDRAM_AW-1:0] req_addr;
   logic [17:0]         req_tag;
   logic                fill;

   assign miss = {obj_cs & ~obj_ok, scr_cs & ~scr_ok, char_cs & ~char_ok};
   assign pick = rr_pick(miss, rr);

   always_comb begin
      req_addr = OBJ_OFFSET + {4'd0, obj_addr};
      req_tag  = obj_addr;
      case (pick)
         CHAR: begin
            req_addr = CHAR_OFFSET + {8'd0, char_addr};
            req_tag  = {4'd0, char_addr};
         end
         SCR: begin
            req_addr = SCR_OFFSET + {5'd0, scr_addr};
            req_tag  = {1'b0, scr_addr};
         end
         default: ;
      endcase
   end

   // Data lands either in WAIT_DATA or together with the ack in WAIT_ACK;
   // a rdy pulse in any other situation has no request behind it.
   assign fill = sdram_rdy & ((state == WAIT_DATA) | ((state == WAIT_ACK) & sdram_ack));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         grant      <= CHAR;
         rr         <= CHAR;
         ctag       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|miss) begin
                  grant      <= pick;
                  sdram_req  <= 1'b1;
                  sdram_addr <= req_addr;
                  ctag       <= req_tag;
                  state      <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  if (sdram_rdy) begin
                     rr    <= next_req(grant);
                     state <= IDLE;
                  end else begin
                     state <= WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               if (sdram_rdy) begin
                  rr    <= next_req(grant);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   jtkunio_arb_slot #(.AW(14)) u_char (
      .clk     (clk),
      .rst_n   (rst_n),
      .cs      (char_cs),
      .addr    (char_addr),
      .wr      (fill && (grant == CHAR)),
      .wr_tag  (ctag[13:0]),
      .wr_data (sdram_din),
      .data    (char_data),
      .ok      (char_ok)
   );

   jtkunio_arb_slot #(.AW(17)) u_scr (
      .clk     (clk),
      .rst_n   (rst_n),
      .cs      (scr_cs),
      .addr    (scr_addr),
      .wr      (fill && (grant == SCR)),
      .wr_tag  (ctag[16:0]),
      .wr_data (sdram_din),
      .data    (scr_data),
      .ok      (scr_ok)
   );

   jtkunio_arb_slot #(.AW(18)) u_obj (
      .clk     (clk),
      .rst_n   (rst_n),
      .cs      (obj_cs),
      .addr    (obj_addr),
      .wr      (fill && (grant == OBJ)),
      .wr_tag  (ctag),
      .wr_data (sdram_din),
      .data    (obj_data),
      .ok      (obj_ok)
   );

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Directed self-checking bench for jtkunio_gfx_arb; the bench plays the
// SDRAM controller and checks slot contents, grant order and addresses.
module tb_jtkunio_gfx_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        char_cs;
   logic [13:0] char_addr;
   logic [31:0] char_data;
   logic        char_ok;
   logic        scr_cs;
   logic [16:0] scr_addr;
   logic [31:0] scr_data;
   logic        scr_ok;
   logic        obj_cs;
   logic [17:0] obj_addr;
   logic [31:0] obj_data;
   logic        obj_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack;
   logic        sdram_rdy;
   logic [31:0] sdram_din;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jtkunio_gfx_arb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_cs    (char_cs),
      .char_addr  (char_addr),
      .char_data  (char_data),
      .char_ok    (char_ok),
      .scr_cs     (scr_cs),
      .scr_addr   (scr_addr),
      .scr_data   (scr_data),
      .scr_ok     (scr_ok),
      .obj_cs     (obj_cs),
      .obj_addr   (obj_addr),
      .obj_data   (obj_data),
      .obj_ok     (obj_ok),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_ack  (sdram_ack),
      .sdram_rdy  (sdram_rdy),
      .sdram_din  (sdram_din)
   );

   task automatic do_reset();
      rst_n     = 1'b0;
      char_cs   = 1'b0;
      scr_cs    = 1'b0;
      obj_cs    = 1'b0;
      char_addr = '0;
      scr_addr  = '0;
      obj_addr  = '0;
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      sdram_din = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Controller model: waits for a request, acks it, then returns data
   // rdy_gap cycles after the ack (0 = same cycle as the ack).
   task automatic serve(input logic [31:0] d, input int rdy_gap,
                        output logic [21:0] addr, output logic to);
      to   = 1'b1;
      addr = '0;
      for (int i = 0; i < 40; i++) begin
         if (sdram_req) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (to) return;
      addr      = sdram_addr;
      sdram_ack = 1'b1;
      if (rdy_gap == 0) begin
         sdram_rdy = 1'b1;
         sdram_din = d;
      end
      @(negedge clk);
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      if (rdy_gap > 0) begin
         repeat (rdy_gap - 1) @(negedge clk);
         sdram_rdy = 1'b1;
         sdram_din = d;
         @(negedge clk);
         sdram_rdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      char_cs = 1'b1;
      scr_cs  = 1'b1;
      obj_cs  = 1'b1;
      #1;
      n_cmp++;
      if (sdram_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req: got %b want 0", sdram_req); end
      n_cmp++;
      if (sdram_addr !== 22'h0) begin n_err++; $display("[TB] FAIL reset_addr: got %h want 0", sdram_addr); end
      n_cmp++;
      if ({char_ok, scr_ok, obj_ok} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_ok: got %b want 000", {char_ok, scr_ok, obj_ok}); end
      n_cmp++;
      if (char_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_data: got %h want 0", char_data); end
      do_reset();
   endtask

   task automatic test_single();
      logic [21:0] a;
      logic        to;
      logic        saw;
      do_reset();
      char_cs   = 1'b1;
      char_addr = 14'h0012;
      #1;
      n_cmp++;
      if (char_ok !== 1'b0) begin n_err++; $display("[TB] FAIL single_miss: got %b want 0", char_ok); end
      serve(32'hA5A5_0001, 2, a, to);
      n_cmp++;
      if (to !== 1'b0) begin n_err++; $display("[TB] FAIL single_timeout: got %b want 0", to); end
      n_cmp++;
      if (a !== 22'h00012) begin n_err++; $display("[TB] FAIL single_addr: got %h want 00012", a); end
      n_cmp++;
      if (char_ok !== 1'b1) begin n_err++; $display("[TB] FAIL single_ok: got %b want 1", char_ok); end
      n_cmp++;
      if (char_data !== 32'hA5A5_0001) begin n_err++; $display("[TB] FAIL single_data: got %h want a5a50001", char_data); end
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (sdram_req) saw = 1'b1;
      end
      n_cmp++;
      if (saw !== 1'b0) begin n_err++; $display("[TB] FAIL single_no_rereq: got %b want 0", saw); end
      char_cs = 1'b0;
   endtask

   task automatic test_all_miss();
      logic [21:0] a;
      logic        to;
      do_reset();
      char_cs   = 1'b1; char_addr = 14'h0100;
      scr_cs    = 1'b1; scr_addr  = 17'h00200;
      obj_cs    = 1'b1; obj_addr  = 18'h00300;
      serve(32'h1111_0000, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h00100) begin n_err++; $display("[TB] FAIL all_grant1: got %h to=%b want 00100", a, to); end
      n_cmp++;
      if ({char_ok, scr_ok, obj_ok} !== 3'b100) begin n_err++; $display("[TB] FAIL all_ok1: got %b want 100", {char_ok, scr_ok, obj_ok}); end
      serve(32'h2222_0000, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h08200) begin n_err++; $display("[TB] FAIL all_grant2: got %h to=%b want 08200", a, to); end
      n_cmp++;
      if ({char_ok, scr_ok, obj_ok} !== 3'b110) begin n_err++; $display("[TB] FAIL all_ok2: got %b want 110", {char_ok, scr_ok, obj_ok}); end
      serve(32'h3333_0000, 3, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h28300) begin n_err++; $display("[TB] FAIL all_grant3: got %h to=%b want 28300", a, to); end
      n_cmp++;
      if ({char_ok, scr_ok, obj_ok} !== 3'b111) begin n_err++; $display("[TB] FAIL all_ok3: got %b want 111", {char_ok, scr_ok, obj_ok}); end
      n_cmp++;
      if ({char_data, scr_data, obj_data} !== {32'h1111_0000, 32'h2222_0000, 32'h3333_0000}) begin
         n_err++; $display("[TB] FAIL all_data: got %h %h %h", char_data, scr_data, obj_data);
      end
      char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
   endtask

   task automatic test_fairness();
      logic [21:0] a;
      logic        to;
      do_reset();
      char_cs = 1'b1; char_addr = 14'h0010;
      obj_cs  = 1'b1; obj_addr  = 18'h00040;
      serve(32'hC000_0010, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h00010) begin n_err++; $display("[TB] FAIL fair_grant1: got %h to=%b want 00010", a, to); end
      char_addr = 14'h0011;
      serve(32'h0B00_0040, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h28040) begin n_err++; $display("[TB] FAIL fair_grant2: got %h to=%b want 28040", a, to); end
      n_cmp++;
      if (obj_ok !== 1'b1 || obj_data !== 32'h0B00_0040) begin n_err++; $display("[TB] FAIL fair_obj: ok=%b data=%h want 1 0b000040", obj_ok, obj_data); end
      serve(32'hC000_0011, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h00011) begin n_err++; $display("[TB] FAIL fair_grant3: got %h to=%b want 00011", a, to); end
      char_cs = 1'b0; obj_cs = 1'b0;
   endtask

   task automatic test_addr_change();
      logic [21:0] a;
      logic        to;
      do_reset();
      scr_cs   = 1'b1;
      scr_addr = 17'h00100;
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (sdram_req) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (to !== 1'b0 || sdram_addr !== 22'h08100) begin n_err++; $display("[TB] FAIL chg_req1: got %h to=%b want 08100", sdram_addr, to); end
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      scr_addr  = 17'h00101;
      @(negedge clk);
      sdram_rdy = 1'b1;
      sdram_din = 32'h5C00_0100;
      @(negedge clk);
      sdram_rdy = 1'b0;
      n_cmp++;
      if (scr_ok !== 1'b0) begin n_err++; $display("[TB] FAIL chg_ok_low: got %b want 0", scr_ok); end
      n_cmp++;
      if (scr_data !== 32'h5C00_0100) begin n_err++; $display("[TB] FAIL chg_data: got %h want 5c000100", scr_data); end
      scr_addr = 17'h00100;
      #1;
      n_cmp++;
      if (scr_ok !== 1'b1) begin n_err++; $display("[TB] FAIL chg_tag: got %b want 1", scr_ok); end
      scr_addr = 17'h00101;
      serve(32'h5C00_0101, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || a !== 22'h08101) begin n_err++; $display("[TB] FAIL chg_req2: got %h to=%b want 08101", a, to); end
      n_cmp++;
      if (scr_ok !== 1'b1 || scr_data !== 32'h5C00_0101) begin n_err++; $display("[TB] FAIL chg_refill: ok=%b data=%h", scr_ok, scr_data); end
      scr_cs = 1'b0;
   endtask

   task automatic test_same_cycle();
      do_reset();
      obj_cs   = 1'b1;
      obj_addr = 18'h3FFFF;
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b1 || sdram_addr !== 22'h67FFF) begin n_err++; $display("[TB] FAIL same_req: req=%b addr=%h want 1 67fff", sdram_req, sdram_addr); end
      n_cmp++;
      if (obj_ok !== 1'b0) begin n_err++; $display("[TB] FAIL same_ok_early: got %b want 0", obj_ok); end
      sdram_ack = 1'b1;
      sdram_rdy = 1'b1;
      sdram_din = 32'hDEAD_BEEF;
      @(negedge clk);
      sdram_ack = 1'b0;
      sdram_rdy = 1'b0;
      n_cmp++;
      if (obj_ok !== 1'b1 || obj_data !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL same_ok: ok=%b data=%h want 1 deadbeef", obj_ok, obj_data); end
      n_cmp++;
      if (sdram_req !== 1'b0) begin n_err++; $display("[TB] FAIL same_req_low: got %b want 0", sdram_req); end
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b0) begin n_err++; $display("[TB] FAIL same_idle: got %b want 0", sdram_req); end
      obj_cs = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [21:0] a;
      logic        to;
      do_reset();
      obj_cs   = 1'b1;
      obj_addr = 18'h00005;
      serve(32'h0B0B_0005, 1, a, to);
      n_cmp++;
      if (to !== 1'b0 || obj_ok !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_prefill: ok=%b to=%b want 1 0", obj_ok, to); end
      char_cs   = 1'b1;
      char_addr = 14'h0020;
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (sdram_req) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (to !== 1'b0 || sdram_addr !== 22'h00020) begin n_err++; $display("[TB] FAIL rmid_req: got %h to=%b want 00020", sdram_addr, to); end
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin n_err++; $display("[TB] FAIL rmid_sdram: req=%b addr=%h want 0 0", sdram_req, sdram_addr); end
      n_cmp++;
      if ({char_ok, scr_ok, obj_ok} !== 3'b000) begin n_err++; $display("[TB] FAIL rmid_ok: got %b want 000", {char_ok, scr_ok, obj_ok}); end
      char_cs = 1'b0;
      obj_cs  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sdram_rdy = 1'b1;
      sdram_din = 32'hBAD0_0020;
      @(negedge clk);
      sdram_rdy = 1'b0;
      n_cmp++;
      if (sdram_req !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_stray_req: got %b want 0", sdram_req); end
      char_cs   = 1'b1;
      char_addr = 14'h0020;
      #1;
      n_cmp++;
      if (char_ok !== 1'b0 || char_data !== 32'h0) begin n_err++; $display("[TB] FAIL rmid_stray: ok=%b data=%h want 0 0", char_ok, char_data); end
      @(negedge clk);
      char_cs = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_miss();
      test_fairness();
      test_addr_change();
      test_same_cycle();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
